// File: rtl/id_ex_stage_if.sv
// Handshake and operand bus between fetch/regfile, the id_ex_stage register and execute.
// Optional writeback bypass signals exist only when ID_EX_FORWARD_EN is defined.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_op;
  logic            out_op_imm;
  logic            out_is_branch;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;
`ifdef ID_EX_FORWARD_EN
  logic            fwd_we;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport slave (
    input  in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
           fwd_we, fwd_rd, fwd_data,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_a, alu_b, out_funct3,
           out_funct7, out_op, out_op_imm, out_is_branch, out_rd, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
           fwd_we, fwd_rd, fwd_data,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_a, alu_b, out_funct3,
           out_funct7, out_op, out_op_imm, out_is_branch, out_rd, out_pc, out_illegal
  );
`else
  modport slave (
    input  in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_a, alu_b, out_funct3,
           out_funct7, out_op, out_op_imm, out_is_branch, out_rd, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_a, alu_b, out_funct3,
           out_funct7, out_op, out_op_imm, out_is_branch, out_rd, out_pc, out_illegal
  );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// Decode/operand stage: builds ALU operands and function controls into a single-entry
// valid/ready pipeline register. Optional macro ID_EX_FORWARD_EN adds a writeback bypass.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            op;
    logic            op_imm;
    logic            is_branch;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } stage_t;

  stage_t          dec;
  stage_t          stage_d;
  stage_t          stage_q;
  logic            valid_d;
  logic            valid_q;
  logic            load;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign opcode       = bus.in_instr[6:0];
  assign imm_i        = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u        = {bus.in_instr[31:12], 12'b0};
  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];
  assign bus.in_ready = rst_n && !bus.flush && (!valid_q || bus.out_ready);
  assign load         = bus.in_valid && bus.in_ready;

  // Operand fetch: x0 reads as zero, optional bypass from writeback wins over the regfile
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (bus.rs1_addr == 5'd0) begin
      rs1_val = '0;
    end else begin
`ifdef ID_EX_FORWARD_EN
      if (bus.fwd_we && (bus.fwd_rd == bus.rs1_addr)) begin
        rs1_val = bus.fwd_data;
      end else begin
        rs1_val = bus.rs1_data;
      end
`else
      rs1_val = bus.rs1_data;
`endif
    end
    if (bus.rs2_addr == 5'd0) begin
      rs2_val = '0;
    end else begin
`ifdef ID_EX_FORWARD_EN
      if (bus.fwd_we && (bus.fwd_rd == bus.rs2_addr)) begin
        rs2_val = bus.fwd_data;
      end else begin
        rs2_val = bus.rs2_data;
      end
`else
      rs2_val = bus.rs2_data;
`endif
    end
  end

  // Opcode decode into the next register contents
  always_comb begin
    dec    = '0;
    dec.pc = bus.in_pc;
    case (opcode)
      OPC_OP: begin
        dec.a      = rs1_val;
        dec.b      = rs2_val;
        dec.funct3 = bus.in_instr[14:12];
        dec.funct7 = bus.in_instr[31:25];
        dec.op     = 1'b1;
        dec.rd     = bus.in_instr[11:7];
      end
      OPC_OP_IMM: begin
        dec.a      = rs1_val;
        dec.funct3 = bus.in_instr[14:12];
        dec.op_imm = 1'b1;
        dec.rd     = bus.in_instr[11:7];
        // Shifts carry their funct7 separately, so b is only the shift amount
        case (bus.in_instr[14:12])
          3'b001, 3'b101: begin
            dec.funct7 = bus.in_instr[31:25];
            dec.b      = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};
          end
          default: begin
            dec.funct7 = 7'd0;
            dec.b      = imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        dec.b      = imm_u;
        dec.op_imm = 1'b1;
        dec.rd     = bus.in_instr[11:7];
      end
      OPC_AUIPC: begin
        dec.a      = bus.in_pc;
        dec.b      = imm_u;
        dec.op_imm = 1'b1;
        dec.rd     = bus.in_instr[11:7];
      end
      OPC_BRANCH: begin
        dec.a         = rs1_val;
        dec.b         = rs2_val;
        dec.funct3    = bus.in_instr[14:12];
        dec.is_branch = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Next state of the pipeline register: flush beats load, load beats consume
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      stage_d = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.alu_a         = stage_q.a;
  assign bus.alu_b         = stage_q.b;
  assign bus.out_funct3    = stage_q.funct3;
  assign bus.out_funct7    = stage_q.funct7;
  assign bus.out_op        = stage_q.op;
  assign bus.out_op_imm    = stage_q.op_imm;
  assign bus.out_is_branch = stage_q.is_branch;
  assign bus.out_rd        = stage_q.rd;
  assign bus.out_pc        = stage_q.pc;
  assign bus.out_illegal   = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage plus hand-written handshake sequences.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  fl;   // {op, op_imm, is_branch, illegal}
    logic [4:0]  rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
  } vec_t;

  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [3:0] fl,
                              input logic [4:0] rd, input logic [4:0] ra1, input logic [4:0] ra2);
    vec_t v;
    v.instr = instr; v.pc = pc; v.d1 = d1; v.d2 = d2; v.a = a; v.b = b;
    v.f3 = f3; v.f7 = f7; v.fl = fl; v.rd = rd; v.ra1 = ra1; v.ra2 = ra2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.rs1_data  = d1;
    bus.rs2_data  = d2;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  initial begin
    vecs[0]  = mk(32'h40335293, 32'h00000000, 32'h80000000, 32'h0000DEAD, 32'h80000000, 32'h00000003,
                  3'b101, 7'b0100000, 4'b0100, 5'd5, 5'd6, 5'd3);
    vecs[1]  = mk(32'hFFF00093, 32'h00000004, 32'h00001234, 32'h00009999, 32'h00000000, 32'hFFFFFFFF,
                  3'b000, 7'd0, 4'b0100, 5'd1, 5'd0, 5'd31);
    vecs[2]  = mk(32'h12345197, 32'h00000100, 32'h00007777, 32'h00008888, 32'h00000100, 32'h12345000,
                  3'b000, 7'd0, 4'b0100, 5'd3, 5'd8, 5'd3);
    vecs[3]  = mk(32'hABCDE237, 32'h00000200, 32'h00005555, 32'h00006666, 32'h00000000, 32'hABCDE000,
                  3'b000, 7'd0, 4'b0100, 5'd4, 5'd27, 5'd28);
    vecs[4]  = mk(32'h002083B3, 32'h00000204, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022,
                  3'b000, 7'd0, 4'b1000, 5'd7, 5'd1, 5'd2);
    vecs[5]  = mk(32'h40418433, 32'h00000208, 32'h0000000A, 32'h0000000B, 32'h0000000A, 32'h0000000B,
                  3'b000, 7'h20, 4'b1000, 5'd8, 5'd3, 5'd4);
    vecs[6]  = mk(32'h000284B3, 32'h0000020C, 32'h00000099, 32'h00000077, 32'h00000099, 32'h00000000,
                  3'b000, 7'd0, 4'b1000, 5'd9, 5'd5, 5'd0);
    vecs[7]  = mk(32'h40209463, 32'h00000210, 32'h00000033, 32'h00000044, 32'h00000033, 32'h00000044,
                  3'b001, 7'd0, 4'b0010, 5'd0, 5'd1, 5'd2);
    vecs[8]  = mk(32'h8005E513, 32'h00000214, 32'h00000F0F, 32'h00000001, 32'h00000F0F, 32'hFFFFF800,
                  3'b110, 7'd0, 4'b0100, 5'd10, 5'd11, 5'd0);
    vecs[9]  = mk(32'h01F11093, 32'h00000218, 32'h000000F0, 32'h00000005, 32'h000000F0, 32'h0000001F,
                  3'b001, 7'd0, 4'b0100, 5'd1, 5'd2, 5'd31);
    vecs[10] = mk(32'hFFFFFFFF, 32'h0000021C, 32'h00000001, 32'h00000002, 32'h00000000, 32'h00000000,
                  3'b000, 7'd0, 4'b0001, 5'd0, 5'd31, 5'd31);

`ifdef ID_EX_FORWARD_EN
    bus.fwd_we   = 1'b0;
    bus.fwd_rd   = 5'd0;
    bus.fwd_data = 32'd0;
`endif

    // reset held two cycles with an instruction offered
    rst_n = 1'b0;
    drive(1'b1, 32'h002083B3, 32'h00000040, 32'h11, 32'h22, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_a", bus.alu_a, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // table: back-to-back loads with out_ready held high
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].d1, vecs[i].d2, 1'b1, 1'b0);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("v%0d_rs1_addr", i), 32'(bus.rs1_addr), 32'(vecs[i].ra1));
      chk($sformatf("v%0d_rs2_addr", i), 32'(bus.rs2_addr), 32'(vecs[i].ra2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].a);
      chk($sformatf("v%0d_alu_b", i), bus.alu_b, vecs[i].b);
      chk($sformatf("v%0d_funct3", i), 32'(bus.out_funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d_funct7", i), 32'(bus.out_funct7), 32'(vecs[i].f7));
      chk($sformatf("v%0d_flags", i),
          32'({bus.out_op, bus.out_op_imm, bus.out_is_branch, bus.out_illegal}), 32'(vecs[i].fl));
      chk($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].pc);
      @(negedge clk);
    end

    // consume without refill; read addresses valid with in_valid low
    drive(1'b0, 32'h002083B3, 32'h00000400, 32'h11, 32'h22, 1'b1, 1'b0);
    #1;
    chk("idle_rs1_addr", 32'(bus.rs1_addr), 32'd1);
    chk("idle_rs2_addr", 32'(bus.rs2_addr), 32'd2);
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // load ADD then stall three cycles while SUB is offered
    @(negedge clk);
    drive(1'b1, 32'h002083B3, 32'h00000400, 32'h11, 32'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("stall_load_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h40418433, 32'h00000404, 32'h0A, 32'h0B, 1'b0, 1'b0);
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_alu_a", bus.alu_a, 32'h11);
      chk("stall_alu_b", bus.alu_b, 32'h22);
      chk("stall_rd", 32'(bus.out_rd), 32'd7);
      chk("stall_pc", bus.out_pc, 32'h400);
    end

    // simultaneous consume and load: no bubble
    @(negedge clk);
    drive(1'b1, 32'h40418433, 32'h00000404, 32'h0A, 32'h0B, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("swap_valid", 32'(bus.out_valid), 32'd1);
    chk("swap_alu_a", bus.alu_a, 32'h0A);
    chk("swap_alu_b", bus.alu_b, 32'h0B);
    chk("swap_funct7", 32'(bus.out_funct7), 32'h20);
    chk("swap_rd", 32'(bus.out_rd), 32'd8);

    // flush with in_valid high: dropped and not accepted
    @(negedge clk);
    drive(1'b1, 32'h002083B3, 32'h00000408, 32'h11, 32'h22, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h002083B3, 32'h00000408, 32'h11, 32'h22, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);

    // reset during a stall drops the held instruction
    @(negedge clk);
    drive(1'b1, 32'h12345197, 32'h00000100, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_alu_a", bus.alu_a, 32'h100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_alu_a", bus.alu_a, 32'd0);
    chk("mid_rst_alu_b", bus.alu_b, 32'd0);
    chk("mid_rst_pc", bus.out_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ID_EX_FORWARD_EN
    // bypass hit on both operands
    drive(1'b1, 32'h001083B3, 32'h00000500, 32'h0, 32'h0, 1'b1, 1'b0);
    bus.fwd_we   = 1'b1;
    bus.fwd_rd   = 5'd1;
    bus.fwd_data = 32'h000000A5;
    @(posedge clk); #1;
    chk("fwd_alu_a", bus.alu_a, 32'hA5);
    chk("fwd_alu_b", bus.alu_b, 32'hA5);
    // fwd_rd of zero never bypasses
    @(negedge clk);
    drive(1'b1, 32'h001083B3, 32'h00000504, 32'h11, 32'h11, 1'b1, 1'b0);
    bus.fwd_rd = 5'd0;
    @(posedge clk); #1;
    chk("nofwd_alu_a", bus.alu_a, 32'h11);
    chk("nofwd_alu_b", bus.alu_b, 32'h11);
    @(negedge clk);
    bus.fwd_we = 1'b0;
`endif

    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
